pwm_counter: RTL
================

Name: pwm_counter

Overview:
- Timebase counter fed by the register block's counter-programming outputs (period, en, count_reset, upnotdown, prescale).
- Produces counter_val, which goes back to the register block for readback and forward to the PWM comparator stage.
- Counts up or down, once every (prescale+1) enabled clocks, wrapping at period. Emits a one-cycle wrap pulse on every wrap.

Parameters:
- WIDTH, 16, width of counter and period.
- PSC_WIDTH, 8, width of prescale and of the internal prescaler counter.

Ports:
- clk  input  1  peripheral clock
- rst_n  input  1  reset
- en  input  1  count enable; level-sensitive
- count_reset  input  1  synchronous counter clear; level-sensitive
- upnotdown  input  1  1 = count up, 0 = count down
- period  input  WIDTH  terminal count, inclusive
- prescale  input  PSC_WIDTH  tick divider; counter steps every prescale+1 enabled clocks
- counter_val  output  WIDTH  current count, registered
- wrap  output  1  one-cycle pulse, registered; high in the cycle counter_val shows the wrapped value

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset: counter_val=0, wrap=0, internal psc_cnt=0, shadow period=0.
- Tick: tick = en && (psc_cnt >= prescale), combinational.
  - Each clk edge with en=1: tick ? psc_cnt<=0 : psc_cnt<=psc_cnt+1.
  - en=0: psc_cnt and counter_val hold.
  - The >= compare guarantees a tick on the next enabled edge when prescale is lowered below the current psc_cnt; no 8-bit wrap-around.
- Priority per edge: count_reset > tick > hold.
- count_reset=1:
  - counter_val <= upnotdown ? 0 : period_eff; psc_cnt <= 0; wrap <= 0.
  - Applies regardless of en.
  - Held for N cycles, the counter stays cleared for N cycles.
- Up count, on tick:
  - counter_val >= period_eff: counter_val <= 0, wrap <= 1.
  - Otherwise: counter_val <= counter_val+1.
  - The >= handles period lowered below the current count: wrap on the next tick.
- Down count, on tick:
  - counter_val == 0 or counter_val > period_eff: counter_val <= period_eff, wrap <= 1.
  - Otherwise: counter_val <= counter_val-1.
- wrap is 0 on every edge that is not a wrapping tick. It is never high two consecutive cycles unless consecutive ticks both wrap (e.g. period_eff=0, prescale=0).
- period_eff=0: counter_val stays 0; wrap pulses on every tick.
- upnotdown change mid-count: no reload; the new direction applies from the next tick.
- en deassert mid-prescale: psc_cnt is kept. Resuming continues the partial prescale interval.
- Arithmetic is modulo 2^WIDTH. Counting never exceeds period_eff; values above it occur only after a period write and resolve on the next tick.
- Latency: counter_val reflects a tick one clock after the edge at which tick was high, i.e. a registered output with no extra pipeline stage.

Optional Feature:
- Macro PWM_COUNTER_PERIOD_SHADOW_EN.
- Defined:
  - period_eff is a shadow register, loaded from period on reset release (value 0), on any edge where en=0, on count_reset, and on every wrapping tick.
  - A period change while counting takes effect only after the current cycle completes.
- Undefined: period_eff = period (live). No shadow register is synthesised.

Test Plan:
- period=3, prescale=0, up=1, en=1 from reset -> counter_val 1,2,3,0,1 on successive clocks; wrap=1 only in the cycle showing 0.
- period=3, prescale=2, up=1 -> counter_val changes every 3rd clock: 0,0,0,1,1,1,2...; en dropped for 5 clocks mid-interval -> value and prescale phase frozen, resumes exactly.
- period=2, up=0, en=1 after count_reset -> counter_val 2,1,0,2,1; wrap high in the cycles showing 2 after 0.
- Counting up at value 7, period=10, assert count_reset 2 cycles with en=1 -> counter_val=0 both cycles, wrap=0; counting resumes 1,2.
- Up at value 8, period changed 10->5:
  - Macro undefined: next tick 0 with wrap.
  - Macro defined: continues 9,10,0 (wrap), then 1..5,0.
- rst_n asserted mid-count at counter_val=0x1234, asynchronously without clk edge -> counter_val=0, wrap=0 immediately. After release with prescale=4, first increment occurs on the 5th enabled clock.

Source files
------------

// File: rtl/pwm_counter.sv
// PWM timebase counter: prescaled up/down count with wrap pulse at an inclusive period.
// Optional macro PWM_COUNTER_PERIOD_SHADOW_EN latches the period so changes apply only at cycle boundaries.
module pwm_counter #(
    parameter int WIDTH     = 16,
    parameter int PSC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 count_reset,
    input  logic                 upnotdown,
    input  logic [WIDTH-1:0]     period,
    input  logic [PSC_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]     counter_val,
    output logic                 wrap
);

    logic [WIDTH-1:0]     counter_q, counter_d;
    logic                 wrap_q, wrap_d;
    logic [PSC_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
    logic [WIDTH-1:0]     period_eff;
    logic                 tick;

    // >= rather than == so that lowering prescale never strands psc_cnt above it.
    assign tick = en && (psc_cnt_q >= prescale);

    always_comb begin
        counter_d = counter_q;
        wrap_d    = 1'b0;
        psc_cnt_d = psc_cnt_q;
        if (count_reset) begin
            counter_d = upnotdown ? '0 : period_eff;
            psc_cnt_d = '0;
        end else if (en) begin
            if (tick) begin
                psc_cnt_d = '0;
                if (upnotdown) begin
                    if (counter_q >= period_eff) begin
                        counter_d = '0;
                        wrap_d    = 1'b1;
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end else begin
                    // A count above period (after a period write) reloads like an underflow.
                    if ((counter_q == '0) || (counter_q > period_eff)) begin
                        counter_d = period_eff;
                        wrap_d    = 1'b1;
                    end else begin
                        counter_d = counter_q - 1'b1;
                    end
                end
            end else begin
                psc_cnt_d = psc_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q <= '0;
            wrap_q    <= 1'b0;
            psc_cnt_q <= '0;
        end else begin
            counter_q <= counter_d;
            wrap_q    <= wrap_d;
            psc_cnt_q <= psc_cnt_d;
        end
    end

`ifdef PWM_COUNTER_PERIOD_SHADOW_EN
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_load;

    // Reload whenever the counter is idle, cleared, or has just completed a cycle.
    assign period_load = !en || count_reset || wrap_d;

    always_comb begin
        period_d = period_q;
        if (period_load) begin
            period_d = period;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
        end else begin
            period_q <= period_d;
        end
    end

    assign period_eff = period_q;
`else
    assign period_eff = period;
`endif

    assign counter_val = counter_q;
    assign wrap        = wrap_q;

endmodule
